// File: rtl/t30_stack_node.sv
// t30_stack_node
// ---------------------------------------------------------------------------
// Stack memory node for the TIS-100 mesh. Neighbouring compute nodes push
// signed words in on any of four directions and pop them back, last-in
// first-out, on any of four directions. At most one push and one pop happen
// per cycle; each side picks its port with its own round-robin pointer.
//
// Ports
//   clk, reset                      clock and synchronous active-high reset
//   <dir>_in_data  [WIDTH]          word offered for push on that direction
//   <dir>_in_valid                  push request
//   <dir>_in_ready                  push accepted when valid & ready
//   <dir>_out_data [WIDTH]          current top of stack (0 when empty),
//                                   identical on all four directions
//   <dir>_out_valid                 pop offer
//   <dir>_out_ready                 pop request, pop happens on valid & ready
//   <dir> is left (0), right (1), up (2), down (3) in arbitration order.
// ---------------------------------------------------------------------------
module t30_stack_node #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [WIDTH-1:0] left_in_data,
    input  logic             left_in_valid,
    output logic             left_in_ready,
    input  logic [WIDTH-1:0] right_in_data,
    input  logic             right_in_valid,
    output logic             right_in_ready,
    input  logic [WIDTH-1:0] up_in_data,
    input  logic             up_in_valid,
    output logic             up_in_ready,
    input  logic [WIDTH-1:0] down_in_data,
    input  logic             down_in_valid,
    output logic             down_in_ready,

    output logic [WIDTH-1:0] left_out_data,
    output logic             left_out_valid,
    input  logic             left_out_ready,
    output logic [WIDTH-1:0] right_out_data,
    output logic             right_out_valid,
    input  logic             right_out_ready,
    output logic [WIDTH-1:0] up_out_data,
    output logic             up_out_valid,
    input  logic             up_out_ready,
    output logic [WIDTH-1:0] down_out_data,
    output logic             down_out_valid,
    input  logic             down_out_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [1:0]       in_rr;
    logic [1:0]       out_rr;

    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] in_data [4];

    logic [1:0]       in_grant;
    logic [1:0]       out_grant;
    logic             in_found;
    logic             out_found;
    logic [1:0]       in_idx;
    logic [1:0]       out_idx;

    logic             push_fire;
    logic             pop_fire;
    logic [WIDTH-1:0] push_data;
    logic [CW-1:0]    top_idx;
    logic [CW-1:0]    wr_idx;
    logic [WIDTH-1:0] top_data;

    // Gather the four directions into indexed vectors so that the arbiters
    // and the datapath can work on a port number instead of names.
    assign in_valid   = {down_in_valid, up_in_valid, right_in_valid, left_in_valid};
    assign out_ready  = {down_out_ready, up_out_ready, right_out_ready, left_out_ready};
    assign in_data[0] = left_in_data;
    assign in_data[1] = right_in_data;
    assign in_data[2] = up_in_data;
    assign in_data[3] = down_in_data;

    // Push arbiter: walk the ports starting at the round-robin pointer and
    // take the first one that is requesting. With nobody requesting, the
    // pointer's own port is offered ready so a neighbour that raises valid
    // later can complete in a single cycle.
    always_comb begin
        in_grant = in_rr;
        in_found = 1'b0;
        in_idx   = '0;
        for (int i = 0; i < 4; i++) begin
            in_idx = in_rr + 2'(i);
            if (!in_found && in_valid[in_idx]) begin
                in_grant = in_idx;
                in_found = 1'b1;
            end
        end
    end

    // Pop arbiter: same scan, driven by the neighbours' ready lines. The
    // connection rule guarantees those readies never depend on our valids,
    // so this does not form a combinational loop.
    always_comb begin
        out_grant = out_rr;
        out_found = 1'b0;
        out_idx   = '0;
        for (int i = 0; i < 4; i++) begin
            out_idx = out_rr + 2'(i);
            if (!out_found && out_ready[out_idx]) begin
                out_grant = out_idx;
                out_found = 1'b1;
            end
        end
    end

    // A full stack refuses every push even when a pop happens in the same
    // cycle; that keeps ready independent of the pop side. Reset silences
    // both handshakes so nothing is accepted or offered while it is high.
    assign in_ready  = (count != FULL && !reset) ? (4'b0001 << in_grant) : 4'b0000;
    assign out_valid = (count != '0 && !reset) ? (4'b0001 << out_grant) : 4'b0000;

    assign push_fire = |(in_valid & in_ready);
    assign pop_fire  = |(out_valid & out_ready);
    assign push_data = in_data[in_grant];

    // The top entry sits just below count. A push that coincides with a pop
    // overwrites that top slot, since the old top leaves in the same cycle.
    assign top_idx  = count - 1'b1;
    assign wr_idx   = pop_fire ? top_idx : count;
    assign top_data = (count != '0 && !reset) ? mem[top_idx] : '0;

    assign left_in_ready   = in_ready[0];
    assign right_in_ready  = in_ready[1];
    assign up_in_ready     = in_ready[2];
    assign down_in_ready   = in_ready[3];
    assign left_out_valid  = out_valid[0];
    assign right_out_valid = out_valid[1];
    assign up_out_valid    = out_valid[2];
    assign down_out_valid  = out_valid[3];
    assign left_out_data   = top_data;
    assign right_out_data  = top_data;
    assign up_out_data     = top_data;
    assign down_out_data   = top_data;

    // Storage array. It carries no reset because count alone decides which
    // entries are meaningful; stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Occupancy and arbiter pointers. A simultaneous push and pop leaves
    // count alone. Each pointer moves past the port it just served, which
    // bounds how long any steadily requesting port can be passed over.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            in_rr  <= 2'd0;
            out_rr <= 2'd0;
        end else begin
            if (push_fire && !pop_fire) begin
                count <= count + 1'b1;
            end else if (pop_fire && !push_fire) begin
                count <= count - 1'b1;
            end
            if (push_fire) begin
                in_rr <= in_grant + 2'd1;
            end
            if (pop_fire) begin
                out_rr <= out_grant + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_t30_stack_node.sv
// tb_t30_stack_node
// ---------------------------------------------------------------------------
// Bench for the T30 stack node. A behavioural model (a queue plus two port
// pointers) predicts ready, valid and top-of-stack every cycle. A table of
// hand-derived vectors walks the reset, LIFO, same-cycle push/pop and
// arbitration scenarios; hand-written sequences cover the full stack and a
// mid-operation reset; a randomized phase finishes off.
// ---------------------------------------------------------------------------
module tb_t30_stack_node;

    localparam int DEPTH = 15;
    localparam int WIDTH = 11;

    typedef struct {
        logic              rst;
        logic [3:0]        iv;
        logic [3:0][10:0]  dat;
        logic [3:0]        ordy;
        logic [3:0]        exp_ir;
        logic [3:0]        exp_ov;
        logic [10:0]       exp_data;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [3:0]       in_valid_tb;
    logic [3:0][10:0] in_data_tb;
    logic [3:0]       out_ready_tb;
    logic [3:0]       in_ready_dut;
    logic [3:0]       out_valid_dut;
    logic [3:0][10:0] out_data_dut;

    int passCount;
    int checkCount;

    logic [10:0] stk[$];
    int          mInRr;
    int          mOutRr;

    vec_t tbl[20];

    t30_stack_node #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .left_in_data    (in_data_tb[0]),
        .left_in_valid   (in_valid_tb[0]),
        .left_in_ready   (in_ready_dut[0]),
        .right_in_data   (in_data_tb[1]),
        .right_in_valid  (in_valid_tb[1]),
        .right_in_ready  (in_ready_dut[1]),
        .up_in_data      (in_data_tb[2]),
        .up_in_valid     (in_valid_tb[2]),
        .up_in_ready     (in_ready_dut[2]),
        .down_in_data    (in_data_tb[3]),
        .down_in_valid   (in_valid_tb[3]),
        .down_in_ready   (in_ready_dut[3]),
        .left_out_data   (out_data_dut[0]),
        .left_out_valid  (out_valid_dut[0]),
        .left_out_ready  (out_ready_tb[0]),
        .right_out_data  (out_data_dut[1]),
        .right_out_valid (out_valid_dut[1]),
        .right_out_ready (out_ready_tb[1]),
        .up_out_data     (out_data_dut[2]),
        .up_out_valid    (out_valid_dut[2]),
        .up_out_ready    (out_ready_tb[2]),
        .down_out_data   (out_data_dut[3]),
        .down_out_valid  (out_valid_dut[3]),
        .down_out_ready  (out_ready_tb[3])
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin choice: first requesting port starting at the pointer,
    // otherwise the pointer itself.
    function automatic int pick(int rr, logic [3:0] req);
        for (int k = 0; k < 4; k++) begin
            if (req[(rr + k) % 4]) return (rr + k) % 4;
        end
        return rr;
    endfunction

    function automatic logic [3:0][10:0] allData(logic [10:0] v);
        return {v, v, v, v};
    endfunction

    task automatic checkVal(string name, logic [47:0] act, logic [47:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare this cycle's DUT outputs against the model, then advance the
    // model across the coming clock edge using the same inputs.
    task automatic checkOutput();
        logic [3:0]  eIr;
        logic [3:0]  eOv;
        logic [10:0] eData;
        int          gi;
        int          go;
        bit          doPush;
        bit          doPop;
        gi    = pick(mInRr, in_valid_tb);
        go    = pick(mOutRr, out_ready_tb);
        eIr   = (reset || stk.size() == DEPTH) ? 4'b0000 : 4'(1 << gi);
        eOv   = (reset || stk.size() == 0) ? 4'b0000 : 4'(1 << go);
        eData = (reset || stk.size() == 0) ? 11'd0 : stk[$];
        checkVal("model_in_ready", 48'(in_ready_dut), 48'(eIr));
        checkVal("model_out_valid", 48'(out_valid_dut), 48'(eOv));
        checkVal("model_out_data", 48'(out_data_dut), 48'(allData(eData)));

        if (reset) begin
            stk.delete();
            mInRr  = 0;
            mOutRr = 0;
        end else begin
            doPush = in_valid_tb[gi] && (stk.size() < DEPTH);
            doPop  = out_ready_tb[go] && (stk.size() > 0);
            if (doPop) begin
                void'(stk.pop_back());
                mOutRr = (go + 1) % 4;
            end
            if (doPush) begin
                stk.push_back(in_data_tb[gi]);
                mInRr = (gi + 1) % 4;
            end
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, let the
    // combinational outputs settle, then check them before the rising edge.
    task automatic applyStimulus(logic rst, logic [3:0] iv, logic [3:0][10:0] dat,
                                 logic [3:0] ordy);
        @(negedge clk);
        reset        = rst;
        in_valid_tb  = iv;
        in_data_tb   = dat;
        out_ready_tb = ordy;
        #1;
        checkOutput();
    endtask

    function automatic vec_t mkRow(logic rst, logic [3:0] iv, logic [10:0] dl, logic [10:0] dr,
                                   logic [10:0] du, logic [10:0] dd, logic [3:0] ordy,
                                   logic [3:0] eir, logic [3:0] eov, logic [10:0] edata);
        vec_t r;
        r.rst      = rst;
        r.iv       = iv;
        r.dat      = {dd, du, dr, dl};
        r.ordy     = ordy;
        r.exp_ir   = eir;
        r.exp_ov   = eov;
        r.exp_data = edata;
        return r;
    endfunction

    initial begin
        passCount    = 0;
        checkCount   = 0;
        mInRr        = 0;
        mOutRr       = 0;
        reset        = 1'b1;
        in_valid_tb  = 4'b0000;
        in_data_tb   = '0;
        out_ready_tb = 4'b0000;

        // Port bits: 0 left, 1 right, 2 up, 3 down.
        // Reset with up valid, then LIFO 5/10/15 popped on down.
        tbl[0]  = mkRow(1, 4'h4, 0, 0, 5, 0, 4'h0, 4'h0, 4'h0, 0);
        tbl[1]  = mkRow(1, 4'h4, 0, 0, 5, 0, 4'h0, 4'h0, 4'h0, 0);
        tbl[2]  = mkRow(0, 4'h4, 0, 0, 5, 0, 4'h0, 4'h4, 4'h0, 0);
        tbl[3]  = mkRow(0, 4'h4, 0, 0, 10, 0, 4'h0, 4'h4, 4'h1, 5);
        tbl[4]  = mkRow(0, 4'h4, 0, 0, 15, 0, 4'h0, 4'h4, 4'h1, 10);
        tbl[5]  = mkRow(0, 4'h0, 0, 0, 0, 0, 4'h8, 4'h8, 4'h8, 15);
        tbl[6]  = mkRow(0, 4'h0, 0, 0, 0, 0, 4'h8, 4'h8, 4'h8, 10);
        tbl[7]  = mkRow(0, 4'h0, 0, 0, 0, 0, 4'h8, 4'h8, 4'h8, 5);
        tbl[8]  = mkRow(0, 4'h0, 0, 0, 0, 0, 4'h8, 4'h8, 4'h0, 0);
        // Stack [3], then push 7 on left while popping on down.
        tbl[9]  = mkRow(0, 4'h1, 3, 0, 0, 0, 4'h0, 4'h1, 4'h0, 0);
        tbl[10] = mkRow(0, 4'h1, 7, 0, 0, 0, 4'h8, 4'h1, 4'h8, 3);
        tbl[11] = mkRow(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h2, 4'h1, 7);
        tbl[12] = mkRow(0, 4'h0, 0, 0, 0, 0, 4'h1, 4'h2, 4'h1, 7);
        tbl[13] = mkRow(0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h2, 4'h0, 0);
        // Arbitration after reset: left 1 / right 2, pops on up and down.
        tbl[14] = mkRow(1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        tbl[15] = mkRow(0, 4'h3, 1, 2, 0, 0, 4'h0, 4'h1, 4'h0, 0);
        tbl[16] = mkRow(0, 4'h3, 1, 2, 0, 0, 4'h0, 4'h2, 4'h1, 1);
        tbl[17] = mkRow(0, 4'h0, 0, 0, 0, 0, 4'hC, 4'h4, 4'h4, 2);
        tbl[18] = mkRow(0, 4'h0, 0, 0, 0, 0, 4'hC, 4'h4, 4'h8, 1);
        tbl[19] = mkRow(0, 4'h0, 0, 0, 0, 0, 4'hC, 4'h4, 4'h0, 0);

        $display("[TB] table vectors");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].iv, tbl[i].dat, tbl[i].ordy);
            checkVal($sformatf("tbl%0d_in_ready", i), 48'(in_ready_dut), 48'(tbl[i].exp_ir));
            checkVal($sformatf("tbl%0d_out_valid", i), 48'(out_valid_dut), 48'(tbl[i].exp_ov));
            checkVal($sformatf("tbl%0d_out_data", i), 48'(out_data_dut),
                     48'(allData(tbl[i].exp_data)));
        end

        // Fill to the brim on left, then offer a 16th word.
        $display("[TB] full stack");
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(0, 4'h1, allData(11'(k)), 4'h0);
        end
        applyStimulus(0, 4'h1, allData(11'd16), 4'h0);
        checkVal("full_in_ready", 48'(in_ready_dut), 48'h0);
        checkVal("full_top", 48'(left_top()), 48'd15);
        applyStimulus(0, 4'h1, allData(11'd16), 4'h2);
        checkVal("full_pop_in_ready", 48'(in_ready_dut), 48'h0);
        checkVal("full_pop_valid", 48'(out_valid_dut), 48'h2);
        checkVal("full_pop_data", 48'(out_data_dut[1]), 48'd15);
        applyStimulus(0, 4'h1, allData(11'd16), 4'h0);
        checkVal("refill_in_ready", 48'(in_ready_dut), 48'h1);
        applyStimulus(0, 4'h0, allData(11'd0), 4'h0);
        checkVal("refill_top", 48'(out_data_dut[0]), 48'd16);

        // Reset in the middle of operation with four entries held.
        $display("[TB] mid-operation reset");
        applyStimulus(1, 4'h0, allData(11'd0), 4'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 4'h4, allData(11'(100 + k)), 4'h0);
        end
        applyStimulus(0, 4'h0, allData(11'd0), 4'h0);
        checkVal("pre_reset_top", 48'(out_data_dut[2]), 48'd103);
        applyStimulus(1, 4'h1, allData(11'd9), 4'h0);
        checkVal("in_reset_ready", 48'(in_ready_dut), 48'h0);
        applyStimulus(0, 4'h0, allData(11'd0), 4'h0);
        checkVal("post_reset_valid", 48'(out_valid_dut), 48'h0);
        checkVal("post_reset_data", 48'(out_data_dut), 48'h0);
        applyStimulus(0, 4'h1, allData(11'd9), 4'h0);
        checkVal("post_reset_push_ready", 48'(in_ready_dut), 48'h1);
        applyStimulus(0, 4'h0, allData(11'd0), 4'h0);
        checkVal("post_reset_readback", 48'(out_data_dut[3]), 48'd9);

        // Randomized traffic, alternating push-heavy and pop-heavy phases so
        // the stack visits both full and empty.
        $display("[TB] random traffic");
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 80; c++) begin
                logic [3:0]       iv;
                logic [3:0]       ordy;
                logic [3:0][10:0] dat;
                logic             rst;
                iv   = 4'($urandom);
                ordy = 4'($urandom);
                if (ph % 2 == 0) ordy = ordy & 4'($urandom) & 4'($urandom);
                else             iv   = iv & 4'($urandom) & 4'($urandom);
                for (int p = 0; p < 4; p++) dat[p] = 11'($urandom);
                rst = ($urandom_range(0, 59) == 0);
                applyStimulus(rst, iv, dat, ordy);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    function automatic logic [10:0] left_top();
        return out_data_dut[0];
    endfunction

endmodule
